// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared CPU memory-port types and MMIO test port register map
//
// Contents:
//   memory_mask_t     byte-lane store mask carried on the data-memory port
//   MMIO_*_OFS        byte offsets of the test port registers inside its 16-byte window
//   mmio_reg_t        register select decoded from address bits [3:2]
package cpu_types;

  typedef logic [3:0] memory_mask_t;

  localparam logic [3:0] MMIO_TOHOST_OFS  = 4'h0;
  localparam logic [3:0] MMIO_CONSOLE_OFS = 4'h4;
  localparam logic [3:0] MMIO_CYCLE_OFS   = 4'h8;

  typedef enum logic [1:0] {
    REG_TOHOST   = MMIO_TOHOST_OFS[3:2],
    REG_CONSOLE  = MMIO_CONSOLE_OFS[3:2],
    REG_CYCLE    = MMIO_CYCLE_OFS[3:2],
    REG_RESERVED = 2'd3
  } mmio_reg_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears pointers and count)
//   push, din     write request and data; ignored when full unless a pop happens too
//   full          DEPTH entries held
//   pop, dout     read request and head data (dout valid whenever !empty)
//   empty         no entries held
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_test_port.sv
// rtl/mmio_test_port.sv - memory-mapped test device: exit code, console FIFO, cycle counter, watchdog
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a, mask, we, wd   CPU data-memory port (mask accepted but not decoded)
//   hit, rd           window decode and combinational read data (0 when !hit)
//   done, pass        run finished; finished with exit code 1 and no timeout
//   timeout           watchdog fired
//   exit_code         latched tohost value (all ones on timeout)
//   cycles            cycles since reset, frozen once done
//   con_valid/data    console FIFO head; popped by con_ready
module mmio_test_port
  import cpu_types::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'hF000_0000,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  a,
  input  memory_mask_t mask,
  input  logic         we,
  input  logic [31:0]  wd,
  output logic         hit,
  output logic [31:0]  rd,
  output logic         done,
  output logic         pass,
  output logic         timeout,
  output logic [31:0]  exit_code,
  output logic [31:0]  cycles,
  output logic         con_valid,
  output logic [7:0]   con_data,
  input  logic         con_ready
);

  mmio_reg_t reg_sel;
  logic      wr;
  logic      tohost_wr;
  logic      con_push;
  logic      con_pop;
  logic      wd_fire;
  logic      overflow;
  logic      fifo_full;
  logic      fifo_empty;
  logic      unused_inputs;

  // Byte lanes and the low address bits play no part in decode.
  assign unused_inputs = ^{mask, a[1:0]};

  assign hit       = (a[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = mmio_reg_t'(a[3:2]);
  assign wr        = we && hit;
  assign tohost_wr = wr && (reg_sel == REG_TOHOST) && !done;
  assign con_push  = wr && (reg_sel == REG_CONSOLE);
  assign con_valid = !fifo_empty;
  assign con_pop   = con_valid && con_ready;
  assign wd_fire   = (TIMEOUT_CYCLES != 32'd0) && !done &&
                     (cycles == TIMEOUT_CYCLES - 32'd1);
  assign pass      = done && (exit_code == 32'd1) && !timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      timeout   <= 1'b0;
      overflow  <= 1'b0;
      exit_code <= '0;
      cycles    <= '0;
    end else begin
      if (!done) cycles <= cycles + 32'd1;
      // A program's own verdict beats a watchdog expiring on the same edge.
      if (tohost_wr) begin
        done      <= 1'b1;
        exit_code <= wd;
      end else if (wd_fire) begin
        done      <= 1'b1;
        timeout   <= 1'b1;
        exit_code <= '1;
      end
      if (con_push && fifo_full && !con_pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    rd = '0;
    if (hit) begin
      case (reg_sel)
        REG_TOHOST:  rd = exit_code;
        REG_CONSOLE: rd = {30'b0, overflow, fifo_full};
        REG_CYCLE:   rd = cycles;
        default:     rd = '0;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (con_push),
    .din   (wd[7:0]),
    .full  (fifo_full),
    .pop   (con_pop),
    .dout  (con_data),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mmio_test_port.sv
// tb/tb_mmio_test_port.sv - self-checking bench for mmio_test_port
module tb_mmio_test_port;
  import cpu_types::*;

  localparam logic [31:0] TOHOST  = 32'hF000_0000;
  localparam logic [31:0] CONSOLE = 32'hF000_0004;
  localparam logic [31:0] CYCLE   = 32'hF000_0008;
  localparam logic [31:0] RSVD    = 32'hF000_000C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [31:0]  a;
  memory_mask_t mask;
  logic         we;
  logic [31:0]  wd;
  logic         con_ready;

  logic        m_hit, m_done, m_pass, m_timeout, m_con_valid;
  logic [31:0] m_rd, m_exit, m_cycles;
  logic [7:0]  m_con_data;
  logic        w_hit, w_done, w_pass, w_timeout, w_con_valid;
  logic [31:0] w_rd, w_exit, w_cycles;
  logic [7:0]  w_con_data;

  mmio_test_port dut (
    .clk(clk), .rst(rst), .a(a), .mask(mask), .we(we), .wd(wd),
    .hit(m_hit), .rd(m_rd), .done(m_done), .pass(m_pass), .timeout(m_timeout),
    .exit_code(m_exit), .cycles(m_cycles), .con_valid(m_con_valid),
    .con_data(m_con_data), .con_ready(con_ready)
  );

  mmio_test_port #(.TIMEOUT_CYCLES(32'd10)) dut_wd (
    .clk(clk), .rst(rst), .a(a), .mask(mask), .we(we), .wd(wd),
    .hit(w_hit), .rd(w_rd), .done(w_done), .pass(w_pass), .timeout(w_timeout),
    .exit_code(w_exit), .cycles(w_cycles), .con_valid(w_con_valid),
    .con_data(w_con_data), .con_ready(con_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        exp_hit;
    logic [31:0] exp_rd;
  } rd_vec_t;

  rd_vec_t    vecs [9];
  logic [7:0] exp_q [$];
  logic       exp_ovf;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    a  = addr;
    wd = data;
    we = 1'b1;
    step();
    we = 1'b0;
    a  = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // Drain the console and compare each byte against the scoreboard as it leaves.
  task automatic drain(input int limit, output int got, output logic [7:0] last);
    int budget;
    budget    = limit;
    got       = 0;
    last      = 8'h0;
    con_ready = 1'b1;
    while ((m_con_valid || exp_q.size() != 0) && budget > 0) begin
      if (m_con_valid) begin
        if (exp_q.size() == 0) begin
          chk("con_unexpected_byte", 32'(m_con_data), 32'hFFFF_FFFF);
        end else begin
          chk("con_data", 32'(m_con_data), 32'(exp_q.pop_front()));
        end
        last = m_con_data;
        got++;
      end
      step();
      budget--;
    end
    con_ready = 1'b0;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_valid_after", 32'(m_con_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int         got;
    logic [7:0] last;
    logic [7:0] b;

    vecs[0] = '{32'hF000_0000, 1'b1, 32'd5};
    vecs[1] = '{32'hF000_0002, 1'b1, 32'd5};
    vecs[2] = '{32'hF000_0004, 1'b1, 32'd0};
    vecs[3] = '{32'hF000_0008, 1'b1, 32'd1};
    vecs[4] = '{32'hF000_000B, 1'b1, 32'd1};
    vecs[5] = '{32'hF000_000C, 1'b1, 32'd0};
    vecs[6] = '{32'hF000_0010, 1'b0, 32'd0};
    vecs[7] = '{32'hE000_0000, 1'b0, 32'd0};
    vecs[8] = '{32'hF100_0004, 1'b0, 32'd0};

    a = 32'h0; wd = 32'h0; we = 1'b0; mask = 4'hF; con_ready = 1'b0; rst = 1'b1;

    // Reset state and free-running counter
    do_reset();
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_pass", 32'(m_pass), 32'd0);
    chk("rst_con_valid", 32'(m_con_valid), 32'd0);
    chk("rst_cycles", m_cycles, 32'd0);
    step(5);
    chk("cycles_5", m_cycles, 32'd5);

    // Exit code 1 -> pass; counter takes its last step on the edge done rises
    store(TOHOST, 32'd1);
    chk("t1_done", 32'(m_done), 32'd1);
    chk("t1_pass", 32'(m_pass), 32'd1);
    chk("t1_exit", m_exit, 32'd1);
    chk("t1_cycles", m_cycles, 32'd6);
    step(3);
    chk("t1_cycles_frozen", m_cycles, 32'd6);
    store(TOHOST, 32'd7);
    chk("t1_exit_kept", m_exit, 32'd1);
    chk("t1_pass_kept", 32'(m_pass), 32'd1);

    // Exit code 5 -> fail, then register reads from a table
    do_reset();
    store(TOHOST, 32'd5);
    chk("t2_done", 32'(m_done), 32'd1);
    chk("t2_pass", 32'(m_pass), 32'd0);
    chk("t2_exit", m_exit, 32'd5);
    chk("t2_timeout", 32'(m_timeout), 32'd0);
    store(CYCLE, 32'h1234);
    store(RSVD, 32'h55);
    for (int i = 0; i < 9; i++) begin
      a = vecs[i].addr;
      #1;
      chk($sformatf("vec%0d_hit", i), 32'(m_hit), 32'(vecs[i].exp_hit));
      chk($sformatf("vec%0d_rd", i), m_rd, vecs[i].exp_rd);
    end
    a = 32'h0;

    // Console overflow: 17 pushes into a 16-deep FIFO, then drain
    do_reset();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 17; i++) begin
      b = 8'h41 + 8'(i);
      if (exp_q.size() < 16) exp_q.push_back(b);
      else exp_ovf = 1'b1;
      store(CONSOLE, {24'hA5A5A5, b});
      if (i == 0) begin
        chk("con_first_valid", 32'(m_con_valid), 32'd1);
        chk("con_first_data", 32'(m_con_data), 32'h41);
      end
    end
    a = CONSOLE;
    #1;
    chk("con_status_ovf", m_rd, {30'b0, exp_ovf, 1'b1});
    a = 32'h0;
    drain(40, got, last);
    chk("con_drain_count", 32'(got), 32'd16);
    chk("con_drain_last", 32'(last), 32'h50);

    // Full FIFO: push and pop on the same edge
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'h30 + 8'(i);
      exp_q.push_back(b);
      store(CONSOLE, {24'h0, b});
    end
    a = CONSOLE;
    #1;
    chk("full_status", m_rd, 32'd1);
    wd = 32'h60;
    we = 1'b1;
    con_ready = 1'b1;
    #1;
    chk("sim_head", 32'(m_con_data), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h60);
    step();
    we = 1'b0;
    con_ready = 1'b0;
    #1;
    chk("sim_status", m_rd, 32'd1);
    a = 32'h0;
    drain(40, got, last);
    chk("sim_drain_count", 32'(got), 32'd16);
    chk("sim_last_byte", 32'(last), 32'h60);

    // Reset mid-run discards console contents
    store(CONSOLE, 32'h77);
    chk("midrst_pre_valid", 32'(m_con_valid), 32'd1);
    do_reset();
    chk("midrst_valid", 32'(m_con_valid), 32'd0);

    // Watchdog expiry
    do_reset();
    step(9);
    chk("wd_pre_done", 32'(w_done), 32'd0);
    chk("wd_pre_cycles", w_cycles, 32'd9);
    step();
    chk("wd_done", 32'(w_done), 32'd1);
    chk("wd_timeout", 32'(w_timeout), 32'd1);
    chk("wd_exit", w_exit, 32'hFFFF_FFFF);
    chk("wd_pass", 32'(w_pass), 32'd0);
    chk("wd_cycles", w_cycles, 32'd10);
    step(20);
    chk("nowd_done", 32'(m_done), 32'd0);
    chk("nowd_timeout", 32'(m_timeout), 32'd0);

    // Tohost write on the watchdog's last cycle wins
    do_reset();
    step(9);
    store(TOHOST, 32'd1);
    chk("race_done", 32'(w_done), 32'd1);
    chk("race_timeout", 32'(w_timeout), 32'd0);
    chk("race_exit", w_exit, 32'd1);
    chk("race_pass", 32'(w_pass), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_test_port.md
Name: mmio_test_port

Overview:
- Memory-mapped test device on the CPU data-memory port, a peer of ram downstream of cpu.
- Decodes a small address window and provides three functions:
  - latches a program exit code (tohost), which decides pass/fail;
  - buffers console bytes in a FIFO that the bench drains;
  - runs a cycle counter and a watchdog timeout.
- Top level gates ram write-enable with !hit and muxes rd onto memory_out when hit=1, so branch/ALU program benches end on a definite verdict instead of a fixed delay.

Parameters:
- BASE_ADDR, 32'hF000_0000, base of the 16-byte window; bits [3:0] must be zero.
- FIFO_DEPTH, 16, console FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- a  in  32  data address from cpu (memory_address)
- mask  in  memory_mask_t  store byte mask; accepted, not used for decode
- we  in  1  store strobe
- wd  in  32  store data
- hit  out  1  combinational; a[31:4]==BASE_ADDR[31:4]
- rd  out  32  combinational read data; 0 when hit=0
- done  out  1  run finished (tohost write or timeout)
- pass  out  1  done && exit_code==1 && !timeout
- timeout  out  1  watchdog fired
- exit_code  out  32  latched tohost value
- cycles  out  32  cycles since reset; frozen once done=1
- con_valid  out  1  FIFO non-empty
- con_data  out  8  FIFO head byte
- con_ready  in  1  bench pop strobe

Behaviour:
- Reset (rst=1 at an edge): done, pass, timeout, overflow, exit_code, cycles, and the FIFO pointers/count all go to 0; con_valid=0. Reset mid-run discards FIFO contents.
- Register map, selected by a[3:2] when hit=1; a[1:0] ignored:
  - 0x0 TOHOST:
    - write while done=0 -> next cycle done=1, exit_code=wd.
    - writes while done=1 are ignored.
    - read returns exit_code.
  - 0x4 CONSOLE:
    - write pushes wd[7:0].
    - read returns {30'b0, overflow, full}.
  - 0x8 CYCLE: read returns cycles; writes ignored.
  - 0xC reserved: reads 0; writes ignored.
- Stores are acted on only when we=1 and hit=1. Write side effects take one edge. Reads are combinational, with the same timing as ram.
- cycles:
  - increments every cycle after reset while done=0;
  - stops incrementing in the cycle done rises;
  - wraps modulo 2^32.
- Watchdog:
  - if TIMEOUT_CYCLES!=0, done=0, and cycles==TIMEOUT_CYCLES-1 at an edge, then next cycle done=1, timeout=1, exit_code=32'hFFFF_FFFF;
  - a TOHOST write in the same cycle wins: timeout stays 0 and exit_code=wd.
- FIFO:
  - pop occurs when con_valid && con_ready; con_data is valid whenever con_valid=1 (first-word fall-through).
  - push when full with no pop -> byte dropped, overflow sticky set to 1 until reset.
  - push and pop in the same cycle when full -> both succeed and the count is unchanged.
  - push when empty -> con_valid=1 the next cycle. A pop cannot occur while empty.
- Console writes are accepted after done=1, so the final message still drains.

Decomposition:
- cpu_types package holds:
  - MMIO_TOHOST_OFS, MMIO_CONSOLE_OFS, MMIO_CYCLE_OFS localparams;
  - the 2-bit mmio_reg_t enum for a[3:2].
- Sub-module sync_fifo (WIDTH, DEPTH; clk, rst, push, din, full, pop, dout, empty) holds the console FIFO. Top-level logic keeps decode, the counter, the watchdog and the verdict.

Test Plan:
- Reset held 2 cycles, then release -> done=0, pass=0, con_valid=0, cycles=0; cycles==5 five cycles after release.
- Store 32'h1 to 0xF000_0000 -> next cycle done=1, pass=1, exit_code=1, cycles frozen. A later store of 32'h7 leaves exit_code=1.
- Store 32'h5 to TOHOST -> done=1, pass=0, exit_code=5, timeout=0.
- Console path, con_ready=0:
  - 17 stores of 0x41..0x51 to 0xF000_0004 -> read of CONSOLE returns 3 (full, overflow);
  - raise con_ready -> 16 bytes 0x41..0x50 out in order, then con_valid=0.
- With FIFO full, push 0x60 and pop in the same cycle -> count stays 16, overflow unchanged, 0x60 is the last byte out.
- TIMEOUT_CYCLES=10, no stores -> done=1 and timeout=1 in cycle 10, exit_code=32'hFFFF_FFFF. Repeat with a TOHOST write of 1 in cycle 9 -> pass=1, timeout=0.
